adc_spi_responder: RTL and testbench

- Synthesizable model of a 2-channel, 12-bit SPI ADC in the MCP3202 style.
- It is the responder end of the adc_clk/adc_cs/adc_mosi/adc_miso link that the audio path drives as SPI initiator.
- Used in the FPGA loopback/test build and in simulation in place of the external converter.
- Sample values are supplied by fabric ports.

---
 rtl/adc_spi_responder.sv | 188 ++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// MCP3202-style 2-channel SPI ADC responder: synchronizes the initiator's SCK/CS/MOSI
// into clk, decodes the start/SGL/ODD/MSBF command and shifts the frozen result out on SCK falls.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,  // must be at least 2
  parameter int DATA_BITS   = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adc_clk,
  input  logic                 adc_cs,
  input  logic                 adc_mosi,
  output logic                 adc_miso,
  output logic                 adc_miso_oe,
  input  logic [DATA_BITS-1:0] sample_ch0,
  input  logic [DATA_BITS-1:0] sample_ch1,
  output logic                 conv_done,
  output logic [1:0]           conv_channel
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_CMD        = 3'd2;
  localparam logic [2:0] S_NULL       = 3'd3;
  localparam logic [2:0] S_MSB        = 3'd4;
  localparam logic [2:0] S_LSB        = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           cmd_q, cmd_d;
  logic                 msbf_q, msbf_d;
  logic [DATA_BITS-1:0] result_q, result_d;
  logic [1:0]           chan_q, chan_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic                 done_q, done_d;

  logic [DATA_BITS:0]   diff_01, diff_10;
  logic [DATA_BITS-1:0] conv_result;

  // CS chain and its edge history reset low: a CS held low across reset must not look
  // like a fresh falling edge, so the initiator has to deselect before a new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], adc_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], adc_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // Differential results use one extra bit so a borrow marks a negative value to clamp.
  assign diff_01 = {1'b0, sample_ch0} - {1'b0, sample_ch1};
  assign diff_10 = {1'b0, sample_ch1} - {1'b0, sample_ch0};

  always_comb begin
    if (cmd_q[1])      conv_result = cmd_q[0] ? sample_ch1 : sample_ch0;
    else if (cmd_q[0]) conv_result = diff_10[DATA_BITS] ? '0 : diff_10[DATA_BITS-1:0];
    else               conv_result = diff_01[DATA_BITS] ? '0 : diff_01[DATA_BITS-1:0];
  end

  always_comb begin
    // NOTE: every next-state signal defaults to hold first, so no branch infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    msbf_d   = msbf_q;
    result_d = result_q;
    chan_d   = chan_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    done_d   = 1'b0;
    if (cs_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cs_fall) begin
          state_d = S_WAIT_START;
          oe_d    = 1'b1;
          miso_d  = 1'b0;
        end
        S_WAIT_START: if (sck_rise && mosi_s) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
        S_CMD: if (sck_rise) begin
          cmd_d = {cmd_q[0], mosi_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(2)) begin
            chan_d   = cmd_q;
            msbf_d   = mosi_s;
            result_d = conv_result;
            state_d  = S_NULL;
            cnt_d    = '0;
          end
        end
        S_NULL: if (sck_fall) begin
          miso_d  = 1'b0;
          state_d = S_MSB;
          cnt_d   = '0;
        end
        S_MSB: if (sck_fall) begin
          if (cnt_q != CNT_FULL) begin
            miso_d = result_q[CNT_TOP - cnt_q];
            cnt_d  = cnt_q + 1'b1;
          end else if (msbf_q) begin
            miso_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // R[0] was the last MSB-first bit; the LSB-first tail resumes at R[1].
            miso_d  = result_q[1];
            cnt_d   = CNT_W'(2);
            state_d = S_LSB;
          end
        end
        S_LSB: if (sck_fall) begin
          if (cnt_q != CNT_FULL) begin
            miso_d = result_q[cnt_q];
            cnt_d  = cnt_q + 1'b1;
          end else begin
            miso_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  miso_d  = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= 2'b00;
      msbf_q   <= 1'b0;
      result_q <= '0;
      chan_q   <= 2'b00;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      msbf_q   <= msbf_d;
      result_q <= result_d;
      chan_q   <= chan_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
    end
  end

  assign adc_miso     = miso_q;
  assign adc_miso_oe  = oe_q;
  assign conv_done    = done_q;
  assign conv_channel = chan_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI frames with a slow SCK and checks
// the returned bits, conv_done pulses and conv_channel against hand-computed values.
module tb_adc_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int DATA_BITS   = 12;
  localparam int HALF        = 6;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 adc_clk, adc_cs, adc_mosi;
  logic                 adc_miso, adc_miso_oe;
  logic [DATA_BITS-1:0] sample_ch0, sample_ch1;
  logic                 conv_done;
  logic [1:0]           conv_channel;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  adc_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .DATA_BITS(DATA_BITS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .adc_clk      (adc_clk),
    .adc_cs       (adc_cs),
    .adc_mosi     (adc_mosi),
    .adc_miso     (adc_miso),
    .adc_miso_oe  (adc_miso_oe),
    .sample_ch0   (sample_ch0),
    .sample_ch1   (sample_ch1),
    .conv_done    (conv_done),
    .conv_channel (conv_channel)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with conv_done high; a stretched pulse shows up as an extra count.
  always @(posedge clk) if (conv_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic clk_bit(input logic m, output logic b);
    adc_mosi = m;
    repeat (HALF) @(negedge clk);
    adc_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    adc_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    b = adc_miso;
  endtask

  task automatic send_cmd(input int nlead, input logic sgl, input logic odd,
                          input logic msbf, output logic null_b);
    logic b;
    for (int i = 0; i < nlead; i++) clk_bit(1'b0, b);
    clk_bit(1'b1, b);
    clk_bit(sgl, b);
    clk_bit(odd, b);
    clk_bit(msbf, null_b);
  endtask

  task automatic read_bits(input int n, output logic [31:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < n; i++) begin
      clk_bit(1'b0, b);
      w = {w[30:0], b};
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    adc_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    adc_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; adc_cs = 1'b1; adc_clk = 1'b0; adc_mosi = 1'b0;
    sample_ch0 = '0; sample_ch1 = '0;
    repeat (4) @(negedge clk);
    n_vec++; if (adc_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", adc_miso_oe); end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++; if (adc_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got=%b exp=0", adc_miso); end
    n_vec++; if (adc_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe_after got=%b exp=0", adc_miso_oe); end
    n_vec++; if (conv_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", conv_done); end
    n_vec++; if (conv_channel !== 2'b00) begin n_err++; $display("FAIL reset_chan got=%b exp=00", conv_channel); end
  endtask

  task automatic test_unipolar_ch0();
    logic b; logic [31:0] w; int d0;
    sample_ch0 = 12'hA5C; sample_ch1 = 12'h000;
    d0 = done_cnt;
    cs_low();
    n_vec++; if (adc_miso_oe !== 1'b1) begin n_err++; $display("FAIL u0_oe_on got=%b exp=1", adc_miso_oe); end
    send_cmd(0, 1'b1, 1'b0, 1'b1, b);
    n_vec++; if (b !== 1'b0) begin n_err++; $display("FAIL u0_null got=%b exp=0", b); end
    read_bits(12, w);
    n_vec++; if (w[11:0] !== 12'hA5C) begin n_err++; $display("FAIL u0_data got=%h exp=a5c", w[11:0]); end
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL u0_done_early got=%0d exp=%0d", done_cnt, d0); end
    clk_bit(1'b0, b);
    n_vec++; if (b !== 1'b0) begin n_err++; $display("FAIL u0_tail0 got=%b exp=0", b); end
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL u0_done got=%0d exp=%0d", done_cnt, d0 + 1); end
    n_vec++; if (conv_channel !== 2'b10) begin n_err++; $display("FAIL u0_chan got=%b exp=10", conv_channel); end
    clk_bit(1'b1, b);
    n_vec++; if (done_cnt !== d0 + 1 || b !== 1'b0 || adc_miso_oe !== 1'b1) begin
      n_err++; $display("FAIL u0_done_state done=%0d miso=%b oe=%b exp=%0d,0,1", done_cnt, b, adc_miso_oe, d0 + 1);
    end
    cs_high();
    n_vec++; if (adc_miso_oe !== 1'b0) begin n_err++; $display("FAIL u0_oe_off got=%b exp=0", adc_miso_oe); end
  endtask

  task automatic test_lsb_tail();
    logic b; logic [31:0] w; int d0;
    sample_ch0 = 12'h000; sample_ch1 = 12'h801;
    d0 = done_cnt;
    cs_low();
    send_cmd(0, 1'b1, 1'b1, 1'b0, b);
    read_bits(12, w);
    n_vec++; if (w[11:0] !== 12'h801) begin n_err++; $display("FAIL lsb_msbpart got=%h exp=801", w[11:0]); end
    read_bits(11, w);
    n_vec++; if (w[10:0] !== 11'h001) begin n_err++; $display("FAIL lsb_tail got=%h exp=001", w[10:0]); end
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL lsb_done_early got=%0d exp=%0d", done_cnt, d0); end
    clk_bit(1'b0, b);
    n_vec++; if (done_cnt !== d0 + 1 || b !== 1'b0) begin
      n_err++; $display("FAIL lsb_done done=%0d miso=%b exp=%0d,0", done_cnt, b, d0 + 1);
    end
    n_vec++; if (conv_channel !== 2'b11) begin n_err++; $display("FAIL lsb_chan got=%b exp=11", conv_channel); end
    cs_high();
  endtask

  task automatic test_diff_clamp();
    logic b; logic [31:0] w;
    sample_ch0 = 12'h100; sample_ch1 = 12'h300;
    cs_low();
    send_cmd(0, 1'b0, 1'b0, 1'b1, b);
    read_bits(13, w);
    n_vec++; if (w[12:0] !== 13'h0000) begin n_err++; $display("FAIL diff01_clamp got=%h exp=0000", w[12:0]); end
    n_vec++; if (conv_channel !== 2'b00) begin n_err++; $display("FAIL diff01_chan got=%b exp=00", conv_channel); end
    cs_high();
    cs_low();
    send_cmd(0, 1'b0, 1'b1, 1'b1, b);
    read_bits(13, w);
    n_vec++; if (w[12:1] !== 12'h200) begin n_err++; $display("FAIL diff10 got=%h exp=200", w[12:1]); end
    n_vec++; if (conv_channel !== 2'b01) begin n_err++; $display("FAIL diff10_chan got=%b exp=01", conv_channel); end
    cs_high();
  endtask

  task automatic test_leading_zeros();
    logic b; logic [31:0] w;
    sample_ch0 = 12'h3C7; sample_ch1 = 12'h000;
    cs_low();
    send_cmd(3, 1'b1, 1'b0, 1'b1, b);
    sample_ch0 = 12'h000;
    read_bits(12, w);
    n_vec++; if (w[11:0] !== 12'h3C7) begin n_err++; $display("FAIL lead_frozen got=%h exp=3c7", w[11:0]); end
    cs_high();
  endtask

  task automatic test_abort();
    logic b; logic [31:0] w; int d0;
    sample_ch0 = 12'h5A5;
    d0 = done_cnt;
    cs_low();
    send_cmd(0, 1'b1, 1'b0, 1'b1, b);
    read_bits(5, w);
    n_vec++; if (w[4:0] !== 5'b01011) begin n_err++; $display("FAIL abort_bits got=%b exp=01011", w[4:0]); end
    adc_cs = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    n_vec++; if (adc_miso_oe !== 1'b0 || adc_miso !== 1'b0) begin
      n_err++; $display("FAIL abort_oe oe=%b miso=%b exp=0,0", adc_miso_oe, adc_miso);
    end
    repeat (6) @(negedge clk);
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL abort_nodone got=%0d exp=%0d", done_cnt, d0); end
    sample_ch0 = 12'hFFF;
    cs_low();
    send_cmd(0, 1'b1, 1'b0, 1'b1, b);
    read_bits(13, w);
    n_vec++; if (w[12:1] !== 12'hFFF || w[0] !== 1'b0) begin n_err++; $display("FAIL abort_next got=%h exp=1ffe", w[12:0]); end
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL abort_next_done got=%0d exp=%0d", done_cnt, d0 + 1); end
    cs_high();
  endtask

  task automatic test_reset_midframe();
    logic b; logic [31:0] w; int d0;
    sample_ch0 = 12'hFFF;
    cs_low();
    send_cmd(0, 1'b1, 1'b0, 1'b1, b);
    read_bits(4, w);
    n_vec++; if (adc_miso_oe !== 1'b1 || adc_miso !== 1'b1) begin
      n_err++; $display("FAIL rst_pre oe=%b miso=%b exp=1,1", adc_miso_oe, adc_miso);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (adc_miso !== 1'b0 || adc_miso_oe !== 1'b0 || conv_done !== 1'b0 || conv_channel !== 2'b00) begin
      n_err++; $display("FAIL rst_async miso=%b oe=%b done=%b chan=%b exp=0,0,0,00",
                        adc_miso, adc_miso_oe, conv_done, conv_channel);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    d0 = done_cnt;
    send_cmd(0, 1'b1, 1'b0, 1'b1, b);
    for (int i = 0; i < 4; i++) begin
      clk_bit(1'b0, b);
      n_vec++; if (adc_miso_oe !== 1'b0 || b !== 1'b0) begin
        n_err++; $display("FAIL rst_silent bit%0d oe=%b miso=%b exp=0,0", i, adc_miso_oe, b);
      end
    end
    n_vec++; if (done_cnt !== d0 || conv_channel !== 2'b00) begin
      n_err++; $display("FAIL rst_silent_state done=%0d chan=%b exp=%0d,00", done_cnt, conv_channel, d0);
    end
    cs_high();
    cs_low();
    send_cmd(0, 1'b1, 1'b0, 1'b1, b);
    read_bits(12, w);
    n_vec++; if (w[11:0] !== 12'hFFF) begin n_err++; $display("FAIL rst_recover got=%h exp=fff", w[11:0]); end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_unipolar_ch0();
    test_lsb_tail();
    test_diff_clamp();
    test_leading_zeros();
    test_abort();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog sim time exceeded limit=2ms");
    $fatal(1, "watchdog");
  end

endmodule
